// File: rtl/cntry_vehicle_detector_pkg.sv
// Shared traffic definitions: light codes and loop debounce state encoding.
// Used by the country vehicle detector and the light controller.
package cntry_vehicle_detector_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEB_ON   = 2'd1,
    OCCUPIED = 2'd2,
    DEB_OFF  = 2'd3
  } deb_state_e;

endpackage

// File: rtl/cntry_vehicle_detector_loop_debouncer.sv
// Loop sensor synchroniser, debounce FSM and optional stuck-loop timer.
// Stuck detection is built only when VEH_DET_STUCK_EN is defined.
module cntry_vehicle_detector_loop_debouncer
  import cntry_vehicle_detector_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 64
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       loop_raw,
  output logic       arrival,
  output logic       stuck,
  output deb_state_e state
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            loop_s;
  logic            deb_done;
  logic            arrival_raw;
  deb_state_e      state_q, state_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;

  assign loop_s   = sync2_q;
  assign deb_done = int'(deb_cnt_q) >= (DEB_CYCLES - 1);
  assign state    = state_q;

  // Arrival is a pulse in the cycle whose edge moves DEB_ON into OCCUPIED.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    arrival_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (loop_s) begin
          state_d   = DEB_ON;
          deb_cnt_d = DW'(1);
        end
      end
      DEB_ON: begin
        if (!loop_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_done) begin
          state_d     = OCCUPIED;
          deb_cnt_d   = '0;
          arrival_raw = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      OCCUPIED: begin
        if (!loop_s) begin
          state_d   = DEB_OFF;
          deb_cnt_d = DW'(1);
        end
      end
      DEB_OFF: begin
        if (loop_s) begin
          state_d   = OCCUPIED;
          deb_cnt_d = '0;
        end else if (deb_done) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= loop_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

`ifdef VEH_DET_STUCK_EN
  localparam int OW = $clog2(STUCK_CYCLES + 1);

  logic [OW-1:0] occ_cnt_q, occ_cnt_d;
  logic          stuck_q, stuck_d;

  // Occupancy time saturates at STUCK_CYCLES; the fault itself is sticky.
  always_comb begin
    occ_cnt_d = occ_cnt_q;
    if (state_q == IDLE) begin
      occ_cnt_d = '0;
    end else if ((state_q == OCCUPIED || state_q == DEB_OFF) &&
                 occ_cnt_q != OW'(STUCK_CYCLES)) begin
      occ_cnt_d = occ_cnt_q + OW'(1);
    end
    stuck_d = stuck_q | (occ_cnt_d == OW'(STUCK_CYCLES));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      occ_cnt_q <= '0;
      stuck_q   <= 1'b0;
    end else begin
      occ_cnt_q <= occ_cnt_d;
      stuck_q   <= stuck_d;
    end
  end

  assign stuck   = stuck_q;
  assign arrival = arrival_raw & ~stuck_q;
`else
  assign stuck   = 1'b0;
  assign arrival = arrival_raw;
`endif

endmodule

// File: rtl/cntry_vehicle_detector.sv
// Country-road detector: debounced loop arrivals, queue, departure timer, X request, conflict flag.
// Optional stuck-loop fail-safe enabled with VEH_DET_STUCK_EN.
module cntry_vehicle_detector
  import cntry_vehicle_detector_pkg::*;
#(
  parameter int  DEB_CYCLES   = 4,
  parameter int  PASS_CYCLES  = 3,
  parameter int  QMAX         = 7,
  parameter int  STUCK_CYCLES = 64,
  localparam int QW           = $clog2(QMAX + 1)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          loop_raw,
  input  logic [1:0]    hwy,
  input  logic [1:0]    cntry,
  output logic          X,
  output logic [QW-1:0] queue_cnt,
  output logic          conflict,
  output logic          stuck,
  output deb_state_e    deb_state
);

  localparam int PW = $clog2(PASS_CYCLES + 1);

  logic          arrival;
  logic          departure;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [QW-1:0] queue_q, queue_d;
  logic          x_q, x_d;
  logic          conflict_q, conflict_d;

  cntry_vehicle_detector_loop_debouncer #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES)
  ) u_deb (
    .clock   (clock),
    .clear   (clear),
    .loop_raw(loop_raw),
    .arrival (arrival),
    .stuck   (stuck),
    .state   (deb_state)
  );

  // The pass timer only runs with a vehicle queued, so departure never underflows.
  always_comb begin
    pass_cnt_d = '0;
    departure  = 1'b0;
    if (cntry == GREEN && queue_q != '0) begin
      if (pass_cnt_q == PW'(PASS_CYCLES - 1)) begin
        departure = 1'b1;
      end else begin
        pass_cnt_d = pass_cnt_q + PW'(1);
      end
    end

    queue_d = queue_q;
    if (arrival && !departure) begin
      if (queue_q != QW'(QMAX)) begin
        queue_d = queue_q + QW'(1);
      end
    end else if (departure && !arrival) begin
      queue_d = queue_q - QW'(1);
    end
    if (stuck) begin
      queue_d = '0;
    end

    x_d        = (queue_d != '0);
    conflict_d = conflict_q | ((hwy != RED) && (cntry != RED));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pass_cnt_q <= '0;
      queue_q    <= '0;
      x_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      queue_q    <= queue_d;
      x_q        <= x_d;
      conflict_q <= conflict_d;
    end
  end

  assign X         = x_q;
  assign queue_cnt = queue_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_cntry_vehicle_detector.sv
// Directed self-checking bench for cntry_vehicle_detector (default parameters).
// The stuck-loop scenario is compiled in when VEH_DET_STUCK_EN is defined.
module tb_cntry_vehicle_detector;
  import cntry_vehicle_detector_pkg::*;

  logic       clock;
  logic       clear;
  logic       loop_raw;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       X;
  logic [2:0] queue_cnt;
  logic       conflict;
  logic       stuck;
  deb_state_e deb_state;

  int n_tests = 0;
  int n_fail  = 0;
  int model_q;

  logic [2:0] exp_q[$];
  logic [2:0] exp_v;

  cntry_vehicle_detector dut (
    .clock    (clock),
    .clear    (clear),
    .loop_raw (loop_raw),
    .hwy      (hwy),
    .cntry    (cntry),
    .X        (X),
    .queue_cnt(queue_cnt),
    .conflict (conflict),
    .stuck    (stuck),
    .deb_state(deb_state)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic add_vehicle();
    loop_raw = 1'b1;
    tick(6);
    loop_raw = 1'b0;
    tick(8);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clear    = 1'b1;
    loop_raw = 1'b0;
    hwy      = RED;
    cntry    = RED;
    tick(2);
    check("rst_x", 32'(X), 0);
    check("rst_q", 32'(queue_cnt), 0);
    check("rst_conflict", 32'(conflict), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_state", 32'(deb_state), 32'(IDLE));
    clear = 1'b0;
    tick(2);

    // Three samples high is a glitch
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(10);
    check("glitch_q", 32'(queue_cnt), 0);
    check("glitch_x", 32'(X), 0);
    check("glitch_state", 32'(deb_state), 32'(IDLE));

    // Steady arrival lands on the 6th edge, counted once
    loop_raw = 1'b1;
    tick(5);
    check("arr_e5_q", 32'(queue_cnt), 0);
    check("arr_e5_x", 32'(X), 0);
    tick(1);
    check("arr_e6_q", 32'(queue_cnt), 1);
    check("arr_e6_x", 32'(X), 1);
    tick(4);
    loop_raw = 1'b0;
    tick(15);
    check("arr_once_q", 32'(queue_cnt), 1);
    check("arr_idle", 32'(deb_state), 32'(IDLE));

    add_vehicle();
    check("two_q", 32'(queue_cnt), 2);

    // Yellow never retires vehicles
    cntry = YELLOW;
    tick(10);
    check("yellow_q", 32'(queue_cnt), 2);
    check("yellow_conflict", 32'(conflict), 0);

    cntry = GREEN;
    tick(2);
    check("drain_e2_q", 32'(queue_cnt), 2);
    tick(1);
    check("drain_e3_q", 32'(queue_cnt), 1);
    check("drain_e3_x", 32'(X), 1);
    tick(2);
    check("drain_e5_q", 32'(queue_cnt), 1);
    tick(1);
    check("drain_e6_q", 32'(queue_cnt), 0);
    check("drain_e6_x", 32'(X), 0);
    tick(4);
    check("drain_empty_q", 32'(queue_cnt), 0);
    cntry = RED;

    // Async clear in the middle of DEB_ON with three queued
    repeat (3) add_vehicle();
    check("pre_rst_q", 32'(queue_cnt), 3);
    loop_raw = 1'b1;
    tick(4);
    check("mid_deb_on", 32'(deb_state), 32'(DEB_ON));
    clear = 1'b1;
    #1;
    check("async_q", 32'(queue_cnt), 0);
    check("async_x", 32'(X), 0);
    check("async_state", 32'(deb_state), 32'(IDLE));
    tick(2);
    clear = 1'b0;
    tick(5);
    check("restart_e5_q", 32'(queue_cnt), 0);
    tick(1);
    check("restart_e6_q", 32'(queue_cnt), 1);
    loop_raw = 1'b0;
    tick(8);

    // Arrival and departure on the same edge at queue 1
    loop_raw = 1'b1;
    tick(3);
    cntry = GREEN;
    tick(2);
    check("coin_e5_q", 32'(queue_cnt), 1);
    tick(1);
    check("coin_e6_q", 32'(queue_cnt), 1);
    check("coin_e6_x", 32'(X), 1);
    cntry = RED;
    loop_raw = 1'b0;
    tick(8);
    check("coin_after_q", 32'(queue_cnt), 1);

    // Nine arrivals saturate at 7
    model_q = 1;
    for (int i = 0; i < 9; i++) begin
      model_q = (model_q < 7) ? model_q + 1 : 7;
      exp_q.push_back(3'(model_q));
      add_vehicle();
      exp_v = exp_q.pop_front();
      check("sat_q", 32'(queue_cnt), 32'(exp_v));
    end
    check("sat_x", 32'(X), 1);

    // Conflict detection
    hwy = GREEN;
    tick(2);
    check("hwy_only", 32'(conflict), 0);
    cntry = YELLOW;
    #1;
    check("conf_before", 32'(conflict), 0);
    tick(1);
    check("conf_set", 32'(conflict), 1);
    hwy   = RED;
    cntry = RED;
    tick(5);
    check("conf_sticky", 32'(conflict), 1);
    check("conf_q", 32'(queue_cnt), 7);
    do_clear();
    check("conf_cleared", 32'(conflict), 0);
    hwy   = 2'd3;
    cntry = GREEN;
    tick(1);
    check("conf_code3", 32'(conflict), 1);
    hwy   = RED;
    cntry = RED;
    do_clear();

`ifdef VEH_DET_STUCK_EN
    loop_raw = 1'b1;
    tick(90);
    check("stuck_set", 32'(stuck), 1);
    check("stuck_q", 32'(queue_cnt), 0);
    check("stuck_x", 32'(X), 0);
    loop_raw = 1'b0;
    tick(12);
    add_vehicle();
    check("stuck_ignore_q", 32'(queue_cnt), 0);
    check("stuck_hold", 32'(stuck), 1);
    do_clear();
    check("stuck_cleared", 32'(stuck), 0);
`else
    loop_raw = 1'b1;
    tick(90);
    check("no_stuck", 32'(stuck), 0);
    check("no_stuck_q", 32'(queue_cnt), 1);
    loop_raw = 1'b0;
    tick(8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
